// File: rtl/alu_sequencer.sv
// alu_sequencer: decodes a stream of 10-bit instructions into register-file
// reads, an ALU operation select and a result write-back. The ALU is external;
// this block drives its operands/select and samples its combinational result.
// One instruction is in flight at a time (IDLE -> DECODE -> EXEC -> WB, or
// IDLE -> WB for immediate loads).

module alu_sequencer #(
    parameter int unsigned DW   = 4,
    parameter int unsigned NREG = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [9:0]    instr,
    output logic [DW-1:0] alu_rs,
    output logic [DW-1:0] alu_rt,
    output logic [2:0]    alu_sel,
    input  logic [DW-1:0] alu_rd,
    output logic          done,
    output logic [DW-1:0] result,
    input  logic [1:0]    rf_raddr,
    output logic [DW-1:0] rf_rdata
);

    localparam int unsigned AW = 2;
    localparam int unsigned SW = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WB     = 2'd3
    } state_t;

    state_t         state;
    logic [DW-1:0]  rf [NREG];
    logic [AW-1:0]  dst_q;
    logic [AW-1:0]  src_a_q;
    logic [AW-1:0]  src_b_q;
    logic [SW-1:0]  sel_q;

    // Instruction field views
    logic           f_ld;
    logic [SW-1:0]  f_sel;
    logic [AW-1:0]  f_dst;
    logic [AW-1:0]  f_src_a;
    logic [AW-1:0]  f_src_b;
    logic [DW-1:0]  f_imm;

    assign f_ld    = instr[9];
    assign f_sel   = instr[8:6];
    assign f_dst   = instr[5:4];
    assign f_src_a = instr[3:2];
    assign f_src_b = instr[1:0];
    assign f_imm   = instr[DW-1:0];

    // Debug read port sees write-back as soon as the WB edge has passed
    assign rf_rdata = rf[rf_raddr];

    // Sequencer FSM, register file and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            done     <= 1'b0;
            result   <= '0;
            alu_rs   <= '0;
            alu_rt   <= '0;
            alu_sel  <= '0;
            dst_q    <= '0;
            src_a_q  <= '0;
            src_b_q  <= '0;
            sel_q    <= '0;
            for (int unsigned i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        dst_q    <= f_dst;
                        if (f_ld) begin
                            // Loads skip the ALU entirely; alu_* keep their values
                            result <= f_imm;
                            done   <= 1'b1;
                            state  <= WB;
                        end else begin
                            src_a_q <= f_src_a;
                            src_b_q <= f_src_b;
                            sel_q   <= f_sel;
                            state   <= DECODE;
                        end
                    end
                end
                DECODE: begin
                    // All earlier writes have retired, so a plain read is current
                    alu_rs  <= rf[src_a_q];
                    alu_rt  <= rf[src_b_q];
                    alu_sel <= sel_q;
                    state   <= EXEC;
                end
                EXEC: begin
                    result <= alu_rd;
                    done   <= 1'b1;
                    state  <= WB;
                end
                WB: begin
                    rf[dst_q] <= result;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with an XOR ALU stub and a
// register-file reference model driven by instruction semantics.

module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [9:0] instr = '0;
    logic [3:0] alu_rs;
    logic [3:0] alu_rt;
    logic [2:0] alu_sel;
    logic [3:0] alu_rd;
    logic       done;
    logic [3:0] result;
    logic [1:0] rf_raddr = '0;
    logic [3:0] rf_rdata;

    alu_sequencer #(.DW(4), .NREG(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .instr    (instr),
        .alu_rs   (alu_rs),
        .alu_rt   (alu_rt),
        .alu_sel  (alu_sel),
        .alu_rd   (alu_rd),
        .done     (done),
        .result   (result),
        .rf_raddr (rf_raddr),
        .rf_rdata (rf_rdata)
    );

    always #5 clk = ~clk;

    // ALU stub
    assign alu_rd = alu_rs ^ alu_rt;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [3:0] m_rf [4];
    logic [3:0] m_rs;
    logic [3:0] m_rt;
    logic [2:0] m_sel;
    logic [3:0] m_result;

    function automatic logic [9:0] mk_alu(input logic [2:0] sel, input logic [1:0] dst,
                                          input logic [1:0] a, input logic [1:0] b);
        return {1'b0, sel, dst, a, b};
    endfunction

    function automatic logic [9:0] mk_ld(input logic [1:0] dst, input logic [3:0] imm);
        return {1'b1, 3'b000, dst, imm};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_rf[i] = 4'h0;
        m_rs = 4'h0; m_rt = 4'h0; m_sel = 3'h0; m_result = 4'h0;
    endtask

    // Architectural effect of one instruction: reads happen before the write
    task automatic model_exec(input logic [9:0] ins);
        logic [1:0] dst;
        dst = ins[5:4];
        if (ins[9]) begin
            m_result = ins[3:0];
        end else begin
            m_rs     = m_rf[ins[3:2]];
            m_rt     = m_rf[ins[1:0]];
            m_sel    = ins[8:6];
            m_result = m_rs ^ m_rt;
        end
        m_rf[dst] = m_result;
    endtask

    // Present an instruction at a negedge and return at the negedge after the
    // handshake edge; hs is cyc at the negedge before that edge.
    task automatic send(input logic [9:0] ins, input bit hold, output int hs, output bit ok);
        int guard;
        guard    = 0;
        instr    = ins;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        ok = (guard < 20);
        hs = cyc;
        @(negedge clk);
        if (!hold) in_valid = 1'b0;
    endtask

    // Poll done at negedges; lat is the number of cycles after the handshake
    task automatic wait_done(input int hs, input int bound, output int lat, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        lat = -1;
        while (n < bound) begin
            if (done === 1'b1) begin
                lat = cyc - hs;
                ok  = 1'b1;
                return;
            end
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_rf(input string tag);
        for (int i = 0; i < 4; i++) begin
            rf_raddr = 2'(i);
            #1;
            n_tests++;
            if (rf_rdata !== m_rf[i]) begin
                n_fail++;
                $display("FAIL %s rf[%0d]: got %h expected %h", tag, i, rf_rdata, m_rf[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b expected 1", in_ready); end
        n_tests++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b expected 0", done); end
        n_tests++;
        if (alu_sel !== 3'b000) begin n_fail++; $display("FAIL reset alu_sel: got %b expected 000", alu_sel); end
        n_tests++;
        if (result !== 4'h0) begin n_fail++; $display("FAIL reset result: got %h expected 0", result); end
        check_rf("reset");
    endtask

    task automatic test_loads();
        int hs0, hs1, lat;
        bit ok;
        send(mk_ld(2'd0, 4'h3), 1'b1, hs0, ok);
        model_exec(mk_ld(2'd0, 4'h3));
        wait_done(hs0, 8, lat, ok);
        n_tests++;
        if (!ok || lat != 1) begin n_fail++; $display("FAIL load0 latency: got %0d expected 1", lat); end
        n_tests++;
        if (result !== 4'h3) begin n_fail++; $display("FAIL load0 result: got %h expected 3", result); end
        send(mk_ld(2'd1, 4'hA), 1'b0, hs1, ok);
        model_exec(mk_ld(2'd1, 4'hA));
        n_tests++;
        if (!ok || hs1 - hs0 != 2) begin n_fail++; $display("FAIL load spacing: got %0d expected 2", hs1 - hs0); end
        wait_done(hs1, 8, lat, ok);
        n_tests++;
        if (!ok || lat != 1) begin n_fail++; $display("FAIL load1 latency: got %0d expected 1", lat); end
        n_tests++;
        if (result !== 4'hA) begin n_fail++; $display("FAIL load1 result: got %h expected a", result); end
        @(negedge clk);
        check_rf("loads");
    endtask

    task automatic test_alu_op();
        int hs, lat;
        bit ok;
        send(mk_alu(3'b101, 2'd2, 2'd0, 2'd1), 1'b0, hs, ok);
        model_exec(mk_alu(3'b101, 2'd2, 2'd0, 2'd1));
        @(negedge clk);
        n_tests++;
        if (alu_sel !== 3'b101 || alu_rs !== 4'h3 || alu_rt !== 4'hA) begin
            n_fail++;
            $display("FAIL aluop operands: got sel=%b rs=%h rt=%h expected sel=101 rs=3 rt=a", alu_sel, alu_rs, alu_rt);
        end
        n_tests++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL aluop in_ready busy: got %b expected 0", in_ready); end
        wait_done(hs, 8, lat, ok);
        n_tests++;
        if (!ok || lat != 3) begin n_fail++; $display("FAIL aluop latency: got %0d expected 3", lat); end
        n_tests++;
        if (result !== 4'h9) begin n_fail++; $display("FAIL aluop result: got %h expected 9", result); end
        n_tests++;
        if (alu_rs !== 4'h3 || alu_rt !== 4'hA) begin
            n_fail++; $display("FAIL aluop stable in WB: got rs=%h rt=%h expected rs=3 rt=a", alu_rs, alu_rt);
        end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0 || result !== 4'h9) begin
            n_fail++; $display("FAIL aluop after WB: got done=%b result=%h expected done=0 result=9", done, result);
        end
        check_rf("aluop");
    endtask

    task automatic test_aliasing();
        int hs, ndone;
        bit ok;
        ndone = 0;
        send(mk_alu(3'b000, 2'd0, 2'd0, 2'd0), 1'b1, hs, ok);
        model_exec(mk_alu(3'b000, 2'd0, 2'd0, 2'd0));
        for (int c = 1; c <= 3; c++) begin
            n_tests++;
            if (in_ready !== 1'b0) begin n_fail++; $display("FAIL alias in_ready cycle %0d: got %b expected 0", c, in_ready); end
            if (done === 1'b1) ndone++;
            if (c == 3) begin
                n_tests++;
                if (result !== 4'h0) begin n_fail++; $display("FAIL alias result: got %h expected 0", result); end
            end
            if (c < 3) @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        n_tests++;
        if (ndone != 1) begin n_fail++; $display("FAIL alias retirements: got %0d expected 1", ndone); end
        check_rf("alias");
    endtask

    task automatic test_reader_after_writer();
        int hs, lat;
        bit ok;
        send(mk_ld(2'd1, 4'hF), 1'b0, hs, ok);
        model_exec(mk_ld(2'd1, 4'hF));
        wait_done(hs, 8, lat, ok);
        send(mk_alu(3'b011, 2'd3, 2'd1, 2'd2), 1'b0, hs, ok);
        model_exec(mk_alu(3'b011, 2'd3, 2'd1, 2'd2));
        @(negedge clk);
        n_tests++;
        if (alu_rs !== 4'hF || alu_rt !== 4'h9) begin
            n_fail++; $display("FAIL raw operands: got rs=%h rt=%h expected rs=f rt=9", alu_rs, alu_rt);
        end
        wait_done(hs, 8, lat, ok);
        n_tests++;
        if (!ok || result !== 4'h6) begin n_fail++; $display("FAIL raw result: got %h expected 6", result); end
        @(negedge clk);
        check_rf("raw");
    endtask

    task automatic test_reset_mid_op();
        int hs, lat, ndone;
        bit ok;
        ndone = 0;
        send(mk_alu(3'b001, 2'd3, 2'd1, 2'd2), 1'b0, hs, ok);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (alu_sel !== 3'b000 || done !== 1'b0) begin
            n_fail++; $display("FAIL midreset async clear: got sel=%b done=%b expected sel=000 done=0", alu_sel, done);
        end
        model_reset();
        @(negedge clk);
        if (done === 1'b1) ndone++;
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        n_tests++;
        if (ndone != 0) begin n_fail++; $display("FAIL midreset done pulses: got %0d expected 0", ndone); end
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset in_ready: got %b expected 1", in_ready); end
        check_rf("midreset");
        send(mk_ld(2'd2, 4'h7), 1'b0, hs, ok);
        model_exec(mk_ld(2'd2, 4'h7));
        wait_done(hs, 8, lat, ok);
        send(mk_alu(3'b010, 2'd1, 2'd2, 2'd0), 1'b0, hs, ok);
        model_exec(mk_alu(3'b010, 2'd1, 2'd2, 2'd0));
        wait_done(hs, 8, lat, ok);
        n_tests++;
        if (!ok || lat != 3 || result !== 4'h7) begin
            n_fail++; $display("FAIL midreset recovery: got lat=%0d result=%h expected lat=3 result=7", lat, result);
        end
        @(negedge clk);
        check_rf("recovery");
    endtask

    task automatic test_random();
        int hs, lat, exp_lat;
        bit ok;
        logic [9:0] ins;
        logic [3:0] prev_rs, prev_rt;
        logic [2:0] prev_sel;
        for (int k = 0; k < 40; k++) begin
            ins = 10'($urandom());
            prev_rs = m_rs; prev_rt = m_rt; prev_sel = m_sel;
            model_exec(ins);
            exp_lat = ins[9] ? 1 : 3;
            send(ins, 1'b0, hs, ok);
            if (!ins[9]) @(negedge clk);
            n_tests++;
            if (alu_rs !== m_rs || alu_rt !== m_rt || alu_sel !== m_sel) begin
                n_fail++;
                $display("FAIL rand[%0d] alu outputs ins=%h: got rs=%h rt=%h sel=%b expected rs=%h rt=%h sel=%b (prev rs=%h rt=%h sel=%b)",
                         k, ins, alu_rs, alu_rt, alu_sel, m_rs, m_rt, m_sel, prev_rs, prev_rt, prev_sel);
            end
            wait_done(hs, 8, lat, ok);
            n_tests++;
            if (!ok || lat != exp_lat || result !== m_result) begin
                n_fail++;
                $display("FAIL rand[%0d] retire ins=%h: got lat=%0d result=%h expected lat=%0d result=%h",
                         k, ins, lat, result, exp_lat, m_result);
            end
            @(negedge clk);
            rf_raddr = ins[5:4];
            #1;
            n_tests++;
            if (done !== 1'b0 || rf_rdata !== m_rf[ins[5:4]]) begin
                n_fail++;
                $display("FAIL rand[%0d] writeback: got done=%b rf=%h expected done=0 rf=%h",
                         k, done, rf_rdata, m_rf[ins[5:4]]);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        check_rf("random");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_loads();
        test_alu_op();
        test_aliasing();
        test_reader_after_writer();
        test_reset_mid_op();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
